// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Purpose
//   Drives a time-multiplexed 6-digit common-anode 7-segment board from six
//   static segment codes. The display shows one digit at a time. Each digit slot
//   is SCAN_DIV clocks long and begins with BLANK_CLKS clocks where every digit
//   is off, which stops ghosting between digits. All six codes are snapshotted
//   together once per frame, so the display never shows a mix of two frames.
//   The block also drives the alarm buzzer.
//
// Parameters
//   SCAN_DIV    clocks per digit slot (>= 2)
//   BLANK_CLKS  blank clocks at the start of each slot (1 <= BLANK_CLKS < SCAN_DIV)
//   TONE_DIV    clocks per buzzer half-period (>= 1), used by the tone generator
//
// Build option
//   BUZZER_PWM_EN  when defined, buzzer is a square wave with period
//                  2*TONE_DIV clocks while alarm is high. When undefined,
//                  buzzer is alarm delayed by one register stage.
//
// Ports
//   clk        in   1  system clock, rising edge
//   reset_n    in   1  asynchronous reset, active low
//   seg_hh     in   7  segment code, hours/month high digit
//   seg_hl     in   7  segment code, hours/month low digit
//   seg_mh     in   7  segment code, minutes/day high digit
//   seg_ml     in   7  segment code, minutes/day low digit
//   seg_sh     in   7  segment code, seconds high digit
//   seg_sl     in   7  segment code, seconds low digit
//   alarm      in   1  alarm ringing, level
//   digit_sel  out  6  one-hot digit enable, [5]=hh .. [0]=sl; 0 while blanking
//   seg_out    out  7  segment code for the enabled digit; 0 while blanking
//   buzzer     out  1  buzzer drive
// -----------------------------------------------------------------------------
module seg_scan_driver #(
   parameter int SCAN_DIV   = 4,
   parameter int BLANK_CLKS = 1,
   parameter int TONE_DIV   = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] seg_hh,
   input  logic [6:0] seg_hl,
   input  logic [6:0] seg_mh,
   input  logic [6:0] seg_ml,
   input  logic [6:0] seg_sh,
   input  logic [6:0] seg_sl,
   input  logic       alarm,
   output logic [5:0] digit_sel,
   output logic [6:0] seg_out,
   output logic       buzzer
);

   localparam int            CW        = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CLKS);
   localparam logic [2:0]    IDX_LAST  = 3'd5;

   // Slot timing state
   logic [CW-1:0] cnt;        // clock position inside the current slot
   logic [2:0]    idx;        // current slot, 0=hh .. 5=sl
   logic          load_pend;  // set by reset: take a snapshot at the first edge

   // Frame snapshot of the six codes, index 0=hh .. 5=sl
   logic [6:0]    snap [6];

   logic          slot_end;
   logic          frame_end;
   logic          do_load;
   logic          in_blank;
   logic [5:0]    slot_sel;
   logic [6:0]    slot_seg;

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);
   assign do_load   = load_pend || frame_end;
   assign in_blank  = (cnt < BLANK_END);

   // ---------------------------------------------------------------------------
   // Slot counter and digit index
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         idx       <= '0;
         load_pend <= 1'b1;
      end else begin
         load_pend <= 1'b0;
         if (slot_end) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
               idx <= '0;
            end else begin
               idx <= idx + 3'd1;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Frame snapshot. The reload happens on the last edge of the sl slot. The
   // outputs at that edge still read the old snapshot, and the slot that
   // follows starts blank, so the new codes first appear in the hh slot.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 6; i++) begin
            snap[i] <= '0;
         end
      end else if (do_load) begin
         snap[0] <= seg_hh;
         snap[1] <= seg_hl;
         snap[2] <= seg_mh;
         snap[3] <= seg_ml;
         snap[4] <= seg_sh;
         snap[5] <= seg_sl;
      end
   end

   // ---------------------------------------------------------------------------
   // Digit enable and code for the current slot
   // ---------------------------------------------------------------------------
   always_comb begin
      slot_sel = '0;
      slot_seg = '0;
      case (idx)
         3'd0: begin slot_sel = 6'b100000; slot_seg = snap[0]; end
         3'd1: begin slot_sel = 6'b010000; slot_seg = snap[1]; end
         3'd2: begin slot_sel = 6'b001000; slot_seg = snap[2]; end
         3'd3: begin slot_sel = 6'b000100; slot_seg = snap[3]; end
         3'd4: begin slot_sel = 6'b000010; slot_seg = snap[4]; end
         3'd5: begin slot_sel = 6'b000001; slot_seg = snap[5]; end
         default: begin slot_sel = '0; slot_seg = '0; end
      endcase
   end

   // Registered outputs, one clock behind the slot state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         digit_sel <= '0;
         seg_out   <= '0;
      end else if (in_blank) begin
         digit_sel <= '0;
         seg_out   <= '0;
      end else begin
         digit_sel <= slot_sel;
         seg_out   <= slot_seg;
      end
   end

   // ---------------------------------------------------------------------------
   // Buzzer
   // ---------------------------------------------------------------------------
`ifdef BUZZER_PWM_EN
   localparam int            TW        = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
   localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

   logic [TW-1:0] tone_cnt;

   // The counter starts at 0 on the first alarm clock, so the first toggle to
   // 1 comes TONE_DIV clocks after alarm rises. Dropping alarm clears both
   // the counter and the output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tone_cnt <= '0;
         buzzer   <= 1'b0;
      end else if (!alarm) begin
         tone_cnt <= '0;
         buzzer   <= 1'b0;
      end else if (tone_cnt == TONE_LAST) begin
         tone_cnt <= '0;
         buzzer   <= ~buzzer;
      end else begin
         tone_cnt <= tone_cnt + 1'b1;
      end
   end
`else
   // Without the tone generator TONE_DIV has no effect. Its legal values are
   // all >= 1, so this term is constant true.
   localparam logic TONE_OK = (TONE_DIV >= 1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buzzer <= 1'b0;
      end else begin
         buzzer <= alarm && TONE_OK;
      end
   end
`endif

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Runs two instances side by side: the default configuration
// (SCAN_DIV=4, BLANK_CLKS=1) and a wide-blank configuration
// (SCAN_DIV=8, BLANK_CLKS=3). Both instances share the same inputs.
//
// The reference model counts edges since reset release. From that count it
// derives the frame, slot and phase with plain arithmetic, and it keeps the
// input codes captured at each frame boundary. Table vectors and hand-written
// sequences cover the fixed scenarios. Random inputs, alarm activity and
// resets are then checked against the model.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

   localparam int TONE_DIV = 2;

   // Clock and reset
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // DUT inputs
   logic [6:0] seg_hh, seg_hl, seg_mh, seg_ml, seg_sh, seg_sl;
   logic       alarm;
   logic [41:0] in_codes;
   assign in_codes = {seg_hh, seg_hl, seg_mh, seg_ml, seg_sh, seg_sl};

   // DUT outputs
   logic [5:0] sel4, sel8;
   logic [6:0] seg4, seg8;
   logic       buz4, buz8;

   seg_scan_driver #(.SCAN_DIV(4), .BLANK_CLKS(1), .TONE_DIV(TONE_DIV)) dut (
      .clk(clk), .reset_n(reset_n),
      .seg_hh(seg_hh), .seg_hl(seg_hl), .seg_mh(seg_mh),
      .seg_ml(seg_ml), .seg_sh(seg_sh), .seg_sl(seg_sl),
      .alarm(alarm), .digit_sel(sel4), .seg_out(seg4), .buzzer(buz4)
   );

   seg_scan_driver #(.SCAN_DIV(8), .BLANK_CLKS(3), .TONE_DIV(TONE_DIV)) dut8 (
      .clk(clk), .reset_n(reset_n),
      .seg_hh(seg_hh), .seg_hl(seg_hl), .seg_mh(seg_mh),
      .seg_ml(seg_ml), .seg_sh(seg_sh), .seg_sl(seg_sl),
      .alarm(alarm), .digit_sel(sel8), .seg_out(seg8), .buzzer(buz8)
   );

   // Scoreboard counters
   int n_checks = 0;
   int n_pass   = 0;
   logic mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
      end
   endtask

   task automatic set_codes(input logic [41:0] c);
      {seg_hh, seg_hl, seg_mh, seg_ml, seg_sh, seg_sl} = c;
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   // Expected {digit_sel, seg_out} after edge number e (1-based, counted from
   // reset release). The edge scan position is e-1. Codes are packed hh first.
   function automatic logic [12:0] ref_out(input int unsigned e, input int unsigned sd,
                                           input int unsigned bl, input logic [41:0] codes);
      int unsigned p, slot, phase;
      logic [5:0] sel;
      logic [6:0] code;
      p     = (e - 1) % (6 * sd);
      slot  = p / sd;
      phase = p % sd;
      if (phase < bl) return 13'd0;
      sel  = 6'b100000 >> slot;
      code = codes[41 - 7 * slot -: 7];
      return {sel, code};
   endfunction

   int unsigned k;          // edges since reset release
   int unsigned tone_n;     // consecutive edges that have seen alarm=1
   logic [41:0] snap4, snap8;
   logic [12:0] e_out4, e_out8;
   logic        e_buz;

   // Snapshots are captured at edge 1 and at every edge that is a multiple of
   // the frame length.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         k      <= 0;
         tone_n <= 0;
         snap4  <= '0;
         snap8  <= '0;
         e_out4 <= '0;
         e_out8 <= '0;
         e_buz  <= 1'b0;
      end else begin
         k      <= k + 1;
         e_out4 <= ref_out(k + 1, 4, 1, snap4);
         e_out8 <= ref_out(k + 1, 8, 3, snap8);
         if (k == 0 || ((k + 1) % 24) == 0) snap4 <= in_codes;
         if (k == 0 || ((k + 1) % 48) == 0) snap8 <= in_codes;
`ifdef BUZZER_PWM_EN
         if (!alarm) begin
            tone_n <= 0;
            e_buz  <= 1'b0;
         end else begin
            tone_n <= tone_n + 1;
            e_buz  <= (((tone_n + 1) / TONE_DIV) % 2) == 1;
         end
`else
         e_buz <= alarm;
`endif
      end
   end

   // Continuous comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (mon_en) begin
         check("mdl_sel4", 32'(sel4), 32'(e_out4[12:7]));
         check("mdl_seg4", 32'(seg4), 32'(e_out4[6:0]));
         check("mdl_sel8", 32'(sel8), 32'(e_out8[12:7]));
         check("mdl_seg8", 32'(seg8), 32'(e_out8[6:0]));
         check("mdl_buz4", 32'(buz4), 32'(e_buz));
         check("mdl_buz8", 32'(buz8), 32'(e_buz));
         if (sel8 != 6'd0) check("onehot8", 32'($onehot(sel8)), 32'd1);
         if (sel4 != 6'd0) check("onehot4", 32'($onehot(sel4)), 32'd1);
      end
   end

   // ---------------------------------------------------------------------------
   // Table vectors: one full frame of the default instance
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [41:0] codes;   // input pattern
      logic [5:0]  sel;     // expected digit_sel
      logic [6:0]  seg;     // expected seg_out
   } vec_t;

   vec_t tbl[24];
   localparam logic [41:0] FRAME_CODES = {7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D};

   task automatic run_table(input string tag);
      for (int i = 0; i < 48; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_sel"}, 32'(sel4), 32'(tbl[i % 24].sel));
         check({tag, "_seg"}, 32'(seg4), 32'(tbl[i % 24].seg));
      end
   endtask

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      logic [41:0] rc;
      logic        found;
      logic [5:0]  sel_tmp;
      logic [6:0]  seg_tmp;

      // One frame: each slot has one blank clock, then 3 clocks on that digit
      for (int i = 0; i < 24; i++) begin
         sel_tmp = 6'b100000 >> (i / 4);
         seg_tmp = FRAME_CODES[41 - 7 * (i / 4) -: 7];
         tbl[i].codes = FRAME_CODES;
         tbl[i].sel   = (i % 4 == 0) ? 6'd0 : sel_tmp;
         tbl[i].seg   = (i % 4 == 0) ? 7'd0 : seg_tmp;
      end

      // Reset held with all segments lit on the inputs
      reset_n = 1'b0;
      alarm   = 1'b0;
      set_codes({6{7'h7F}});
      repeat (3) @(negedge clk);
      check("rst_sel4", 32'(sel4), 32'd0);
      check("rst_seg4", 32'(seg4), 32'd0);
      check("rst_buz4", 32'(buz4), 32'd0);
      check("rst_sel8", 32'(sel8), 32'd0);
      check("rst_seg8", 32'(seg8), 32'd0);
      check("rst_buz8", 32'(buz8), 32'd0);
      mon_en = 1'b1;

      // Basic scan order and frame period
      set_codes(tbl[0].codes);
      @(negedge clk);
      reset_n = 1'b1;
      run_table("tbl");

      // Input change during the hh slot is held back until the next frame
      @(negedge clk);
      #2 reset_n = 1'b0;
      seg_ml = 7'h5B;
      @(negedge clk);
      reset_n = 1'b1;
      for (int e = 1; e <= 48; e++) begin
         @(posedge clk);
         #1;
         if (e == 2) seg_ml = 7'h4F;
         if (e >= 14 && e <= 16) begin
            check("midf_old_sel", 32'(sel4), 32'(6'b000100));
            check("midf_old_seg", 32'(seg4), 32'h5B);
         end
         if (e >= 38 && e <= 40) begin
            check("midf_new_sel", 32'(sel4), 32'(6'b000100));
            check("midf_new_seg", 32'(seg4), 32'h4F);
         end
      end

      // Asynchronous reset while the ml digit is shown
      found = 1'b0;
      for (int i = 0; i < 48 && !found; i++) begin
         @(posedge clk);
         #1;
         if (sel4 == 6'b000100) found = 1'b1;
      end
      check("wait_ml_slot", 32'(found), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async_sel4", 32'(sel4), 32'd0);
      check("async_seg4", 32'(seg4), 32'd0);
      check("async_sel8", 32'(sel8), 32'd0);
      set_codes(tbl[0].codes);
      @(negedge clk);
      reset_n = 1'b1;
      run_table("restart");

      // Alarm pulse of 10 clocks
      @(negedge clk);
      alarm = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         #1;
`ifdef BUZZER_PWM_EN
         check("buz_pulse", 32'(buz4), (i <= 10) ? 32'((i / TONE_DIV) % 2) : 32'd0);
`else
         check("buz_pulse", 32'(buz4), (i <= 10) ? 32'd1 : 32'd0);
`endif
         if (i == 10) alarm = 1'b0;
      end

      // Random codes, alarm activity and occasional resets
      rc = in_codes;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         for (int j = 0; j < 6; j++) begin
            if ($urandom_range(0, 5) == 0) rc[j * 7 +: 7] = 7'($urandom);
         end
         set_codes(rc);
         if ($urandom_range(0, 7) == 0) alarm = ~alarm;
         if (!reset_n) begin
            reset_n = 1'b1;
         end else if ($urandom_range(0, 499) == 0) begin
            #2 reset_n = 1'b0;
         end
      end

      @(negedge clk);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
